// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the iterative InvSubBytes engine: one 128-bit state in,
// one 128-bit state out, each side with its own valid/ready pair.
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  // The engine is the slave; whoever feeds blocks and drains results is the master.
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: applies the inverse S-box to the 16 bytes of one
// state, LANES bytes per cycle, byte 0 first, with valid/ready on both sides.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  inv_sub_bytes_seq_if.slave bus
);

  localparam int NSTEP = 16 / LANES;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [127:0]     work, work_next;
  logic [7:0]       lane_out [LANES];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; the chain naturally maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[3'(i + 2)] ^ b[3'(i + 5)] ^ b[3'(i + 7)];
    end
    return y ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(inv_affine(b));
  endfunction

  // Each lane looks at the byte slot selected by the step counter.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_out[l] = inv_sbox(work[(int'(cnt) * LANES + l) * 8 +: 8]);
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    work_next  = work;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_next  = bus.in_state;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          work_next[(int'(cnt) * LANES + l) * 8 +: 8] = lane_out[l];
        end
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NSTEP - 1)) begin
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      // NOTE: the work register is reset too, since out_state is required to
      // read zero after reset rather than stale data.
      work  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      work  <= work_next;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_state = work;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (LANES 4,1,2,8,16) checked against
// an inverse S-box table derived by inverting a forward S-box built from GF math.
module tb_inv_sub_bytes_seq;

  localparam int NDUT = 5;
  localparam int LANES_TBL [NDUT] = '{4, 1, 2, 8, 16};

  logic clk = 1'b0;
  logic rst;

  logic         in_valid_v  [NDUT];
  logic [127:0] in_state_v  [NDUT];
  logic         out_ready_v [NDUT];
  logic         in_ready_v  [NDUT];
  logic         out_valid_v [NDUT];
  logic [127:0] out_state_v [NDUT];
  logic         busy_v      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_seq_if bus ();
    assign bus.in_valid   = in_valid_v[g];
    assign bus.in_state   = in_state_v[g];
    assign bus.out_ready  = out_ready_v[g];
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign out_state_v[g] = bus.out_state;
    assign busy_v[g]      = bus.busy;

    inv_sub_bytes_seq #(.LANES(LANES_TBL[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t       vecs [$];
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from a brute-force inverse plus the forward affine map,
  // then the inverse table by swapping index and value.
  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tbl[x] = s;
      inv_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] din);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[din[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the output handshake.
  task automatic run_block(input int d, input logic [127:0] din,
                           output logic [127:0] dout, output int edges);
    int guard;
    guard = 0;
    while (!in_ready_v[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid_v[d] = 1'b1;
    in_state_v[d] = din;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    in_state_v[d] = rand128();
    while (!out_valid_v[d] && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    dout = out_state_v[d];
    out_ready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_v[d] = 1'b0;
  endtask

  initial begin
    logic [127:0] dout;
    logic [127:0] din;
    logic [127:0] exp;
    int           edges;
    int           guard;
    vec_t         v;

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid_v[d]  = 1'b0;
      in_state_v[d]  = '0;
      out_ready_v[d] = 1'b0;
    end
    build_model();

    v.din = 128'h76abd7fe2b670130c56f6bf27b777c63;
    v.dout = 128'h0f0e0d0c0b0a09080706050403020100;
    vecs.push_back(v);
    v.din = '0;
    v.dout = {16{8'h52}};
    vecs.push_back(v);
    v.din  = 128'h637c0016ed01637c0016ed01637c0016;
    v.dout = 128'h000152ff5309000152ff5309000152ff;
    vecs.push_back(v);
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) begin
        v.din[8*k +: 8]  = fwd_tbl[16*b + k];
        v.dout[8*k +: 8] = 8'(16*b + k);
      end
      vecs.push_back(v);
    end
    for (int r = 0; r < 8; r++) begin
      v.din  = rand128();
      v.dout = ref_block(v.din);
      vecs.push_back(v);
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready[%0d]", d), 128'(in_ready_v[d]), 128'(1));
      check($sformatf("rst_out_valid[%0d]", d), 128'(out_valid_v[d]), 128'(0));
      check($sformatf("rst_out_state[%0d]", d), out_state_v[d], '0);
      check($sformatf("rst_busy[%0d]", d), 128'(busy_v[d]), 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Table vectors on the LANES=4 instance
    foreach (vecs[i]) begin
      run_block(0, vecs[i].din, dout, edges);
      check($sformatf("vec%0d_out", i), dout, vecs[i].dout);
      check($sformatf("vec%0d_latency", i), 128'(edges), 128'(5));
      check($sformatf("vec%0d_in_ready_after", i), 128'(in_ready_v[0]), 128'(1));
      check($sformatf("vec%0d_out_valid_after", i), 128'(out_valid_v[0]), 128'(0));
    end

    // Lane sweep: known vector plus random blocks
    for (int d = 1; d < NDUT; d++) begin
      run_block(d, vecs[0].din, dout, edges);
      check($sformatf("sweep_l%0d_known", LANES_TBL[d]), dout, vecs[0].dout);
      check($sformatf("sweep_l%0d_latency", LANES_TBL[d]), 128'(edges), 128'(16 / LANES_TBL[d] + 1));
      for (int r = 0; r < 3; r++) begin
        din = rand128();
        run_block(d, din, dout, edges);
        check($sformatf("sweep_l%0d_rand%0d", LANES_TBL[d], r), dout, ref_block(din));
      end
    end

    // Backpressure with an ignored input pulse while DONE
    din = rand128();
    exp = ref_block(din);
    in_valid_v[0] = 1'b1;
    in_state_v[0] = din;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    check("bp_busy_run", 128'(busy_v[0]), 128'(1));
    guard = 0;
    while (!out_valid_v[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_out_valid_c%0d", c), 128'(out_valid_v[0]), 128'(1));
      check($sformatf("bp_out_state_c%0d", c), out_state_v[0], exp);
      check($sformatf("bp_in_ready_c%0d", c), 128'(in_ready_v[0]), 128'(0));
      if (c == 3) begin
        in_valid_v[0] = 1'b1;
        in_state_v[0] = rand128();
      end
      if (c == 6) in_valid_v[0] = 1'b0;
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    check("bp_out_state_release", out_state_v[0], exp);
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check("bp_in_ready_after", 128'(in_ready_v[0]), 128'(1));
    check("bp_out_valid_after", 128'(out_valid_v[0]), 128'(0));
    repeat (8) @(negedge clk);
    check("bp_not_queued_valid", 128'(out_valid_v[0]), 128'(0));
    check("bp_not_queued_busy", 128'(busy_v[0]), 128'(0));

    // Reset during the 2nd RUN cycle
    in_valid_v[0] = 1'b1;
    in_state_v[0] = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrun_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("rstrun_busy", 128'(busy_v[0]), 128'(0));
    check("rstrun_in_ready", 128'(in_ready_v[0]), 128'(1));
    check("rstrun_out_state", out_state_v[0], '0);
    run_block(0, vecs[0].din, dout, edges);
    check("rstrun_fresh_out", dout, vecs[0].dout);
    check("rstrun_fresh_latency", 128'(edges), 128'(5));

    // Reset while DONE with the result unconsumed
    in_valid_v[2] = 1'b1;
    in_state_v[2] = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid_v[2] = 1'b0;
    guard = 0;
    while (!out_valid_v[2] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("rstdone_reached", 128'(out_valid_v[2]), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdone_out_valid", 128'(out_valid_v[2]), 128'(0));
    check("rstdone_in_ready", 128'(in_ready_v[2]), 128'(1));
    check("rstdone_busy", 128'(busy_v[2]), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Iterative AES InvSubBytes engine: accepts one 128-bit AES state, applies the inverse S-box to all 16 bytes, returns the result.
- Processes LANES bytes per cycle to trade area for latency.
- Sits in the decryption datapath as the inverse counterpart of the forward S-box used by SubBytes.
- Valid/ready handshakes on both sides.

Parameters:
- LANES, 4, number of inverse S-box instances (bytes processed per cycle); legal values 1, 2, 4, 8, 16; any other value must fail elaboration.
- NSTEP, 16/LANES (derived, localparam), number of processing cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  engine can accept a block.
- in_state  input  128  input state; byte k = in_state[8k+7:8k], k=0..15.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  result; byte k = InvSbox(input byte k).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Inverse S-box per lane (combinational):
  - Inverse affine: b'_i = b_(i+2 mod 8) ^ b_(i+5 mod 8) ^ b_(i+7 mod 8) ^ d_i, d=8'h05.
  - Then multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1; 0 maps to 0.
  - A 256-entry case table is an equivalent, acceptable implementation.
  - Spot values: 63->00, 7c->01, 00->52, 16->ff, ed->53, 01->09.
- Reset (synchronous, rst=1 at a clk edge) → FSM=IDLE, step counter=0, work register=0.
  - Therefore out_valid=0, out_state=0, busy=0, in_ready=1.
  - Reset mid-RUN or mid-DONE aborts the block with no output; in_ready=1 on the cycle after the reset edge.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready, load the work register from in_state, counter=0, go to RUN.
  - RUN: in_ready=0. Each cycle, replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work register with their inverse S-box values; cnt++. When cnt==NSTEP-1 that cycle, go to DONE.
  - DONE: out_valid=1, out_state = work register, held stable while out_ready=0. On out_valid&out_ready, go to IDLE (out_valid=0 next cycle).
- Latency: out_valid rises exactly NSTEP+1 clk edges after the input handshake edge (LANES=4: 5; LANES=1: 17; LANES=16: 2).
- Throughput: one block per NSTEP+2 cycles minimum. No input accepted in DONE (in_ready=0), including the out-handshake cycle.
- in_state is sampled only on the accept edge; later changes to in_state have no effect.
- in_valid while in_ready=0: ignored and not queued; the source must hold it.
- out_state outside DONE reflects partially processed data; it is don't-care and must not be consumed.
- Byte order: processed byte 0 upward. Byte positions are never permuted.
- busy = (FSM != IDLE).

Test Plan:
- Reset then idle: assert rst 2 cycles → in_ready=1, out_valid=0, out_state=0, busy=0.
- Known vector (LANES=4): in_state=128'h76abd7fe2b670130c56f6bf27b777c63, out_ready=1 → out_valid high 5 edges after accept; out_state=128'h0f0e0d0c0b0a09080706050403020100; in_ready=1 one cycle after the out handshake.
- Exhaustive: 16 blocks covering bytes 0x00..0xff, each byte pre-mapped by the existing forward sbox → every output byte equals the original byte. Also in_state all 0x00 → all 0x52.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid stays 1, out_state stable, in_ready=0. Pulse in_valid with a new block meanwhile → ignored; the result is unchanged after out_ready=1.
- Reset mid-RUN: rst on the 2nd RUN cycle → next cycle out_valid=0, busy=0, in_ready=1. A fresh block then produces a correct result with normal latency.
- Parameter sweep: LANES=1,2,8,16 with the known vector → same out_state; latency 17, 9, 3, 2 respectively.
